if_id_stage: RTL and testbench

Fetch-side responder to the hazard unit's stall/flush controls. Owns the fetch PC register, drives the synchronous instruction memory address, and holds the IF/ID pipeline register. It obeys StallF/StallD/FlushD and the redirect from Execute. It keeps instruction integrity across stalls even though the memory's read data is not itself stallable, and it counts stall and flush events for debug.

---
 rtl/if_id_stage_if.sv | 27 ++
 rtl/if_id_stage.sv | 90 +++++++++
 tb/tb_if_id_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/if_id_stage_if.sv
// Bundle between the fetch stage and its environment: hazard controls,
// Execute redirect, instruction memory port, Decode outputs and debug counters.
interface if_id_stage_if;
  logic        i_stall_f;
  logic        i_stall_d;
  logic        i_flush_d;
  logic        i_br_sel;
  logic [31:0] i_br_target;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc_d;
  logic [31:0] o_pc4_d;
  logic [31:0] o_instr_d;
  logic        o_valid_d;
  logic [15:0] o_stall_cnt;
  logic [15:0] o_flush_cnt;

  modport master (
    input  i_stall_f, i_stall_d, i_flush_d, i_br_sel, i_br_target, i_imem_rdata,
    output o_imem_addr, o_pc_d, o_pc4_d, o_instr_d, o_valid_d, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    output i_stall_f, i_stall_d, i_flush_d, i_br_sel, i_br_target, i_imem_rdata,
    input  o_imem_addr, o_pc_d, o_pc4_d, o_instr_d, o_valid_d, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch PC register and IF/ID pipeline register with stall/flush/redirect
// handling, a Decode-word hold buffer, and saturating stall/flush counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  if_id_stage_if.master bus
);

  logic [31:0] pc_f;
  logic [31:0] pc_d;
  logic [31:0] hold_buf;
  logic        valid_d;
  logic        held;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        hold_f;
  logic        hold_d;

  // Freezing Decode alone would drop the word already in flight from memory.
  assign hold_f = bus.i_stall_f | bus.i_stall_d;
  assign hold_d = bus.i_stall_d & ~bus.i_flush_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_f <= RESET_PC;
    end else if (bus.i_br_sel) begin
      pc_f <= {bus.i_br_target[31:2], 2'b00};
    end else if (!hold_f) begin
      pc_f <= pc_f + 32'd4;
    end
  end

  // Memory re-reads the frozen PC during a stall, so the Decode word is
  // captured once on the first stall edge and served from hold_buf after.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_d  <= 1'b0;
      pc_d     <= '0;
      held     <= 1'b0;
      hold_buf <= '0;
    end else if (bus.i_flush_d) begin
      valid_d <= 1'b0;
      pc_d    <= pc_f;
      held    <= 1'b0;
    end else if (hold_d) begin
      held <= 1'b1;
      if (!held) begin
        hold_buf <= bus.i_imem_rdata;
      end
    end else begin
      valid_d <= 1'b1;
      pc_d    <= pc_f;
      held    <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold_d && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (bus.i_flush_d && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    bus.o_instr_d = bus.i_imem_rdata;
    if (!valid_d) begin
      bus.o_instr_d = NOP_INSTR;
    end else if (held) begin
      bus.o_instr_d = hold_buf;
    end
  end

  assign bus.o_imem_addr = pc_f;
  assign bus.o_pc_d      = pc_d;
  assign bus.o_pc4_d     = pc_d + 32'd4;
  assign bus.o_valid_d   = valid_d;
  assign bus.o_stall_cnt = stall_cnt;
  assign bus.o_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: sequential fetch, stalls, redirects,
// PC wrap, counter saturation and reset during a stall.
module tb_if_id_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst1_n = 1'b0;
  logic scramble = 1'b0;
  logic [15:0] scr_cnt = '0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_id_stage_if bus0 ();
  if_id_stage_if bus1 ();

  if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.master));
  if_id_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .bus(bus1.master));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Registered memory models; scramble makes every re-read return a new word
  always @(posedge clk) begin
    scr_cnt <= scr_cnt + 16'd1;
    bus0.i_imem_rdata <= mem_word(bus0.o_imem_addr) ^ (scramble ? {16'hA5A5, scr_cnt} : 32'h0);
    bus1.i_imem_rdata <= mem_word(bus1.o_imem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    tests++; if (bus0.o_imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want %h", bus0.o_imem_addr, 32'h0); end
    tests++; if (bus0.o_pc_d !== 32'h0) begin fails++; $display("FAIL reset_pc_d: got %h want %h", bus0.o_pc_d, 32'h0); end
    tests++; if (bus0.o_pc4_d !== 32'h4) begin fails++; $display("FAIL reset_pc4_d: got %h want %h", bus0.o_pc4_d, 32'h4); end
    tests++; if (bus0.o_instr_d !== 32'h13) begin fails++; $display("FAIL reset_instr: got %h want %h", bus0.o_instr_d, 32'h13); end
    tests++; if (bus0.o_valid_d !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus0.o_valid_d); end
    tests++; if (bus0.o_stall_cnt !== 16'h0 || bus0.o_flush_cnt !== 16'h0) begin fails++; $display("FAIL reset_cnts: got %h/%h want 0/0", bus0.o_stall_cnt, bus0.o_flush_cnt); end
  endtask

  task automatic test_sequential();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bus0.o_pc_d !== 32'(4 * i)) begin fails++; $display("FAIL seq_pc_d[%0d]: got %h want %h", i, bus0.o_pc_d, 32'(4 * i)); end
      tests++; if (bus0.o_instr_d !== 32'h1000_0000 + 32'(i)) begin fails++; $display("FAIL seq_instr[%0d]: got %h want %h", i, bus0.o_instr_d, 32'h1000_0000 + 32'(i)); end
      tests++; if (bus0.o_valid_d !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d]: got %b want 1", i, bus0.o_valid_d); end
    end
    tests++; if (bus0.o_imem_addr !== 32'd12) begin fails++; $display("FAIL seq_addr: got %h want %h", bus0.o_imem_addr, 32'd12); end
  endtask

  task automatic test_load_use();
    bus0.i_stall_f = 1'b1; bus0.i_stall_d = 1'b1;
    step();
    bus0.i_stall_f = 1'b0; bus0.i_stall_d = 1'b0;
    tests++; if (bus0.o_pc_d !== 32'd8) begin fails++; $display("FAIL lu_pc_d: got %h want %h", bus0.o_pc_d, 32'd8); end
    tests++; if (bus0.o_instr_d !== 32'h1000_0002) begin fails++; $display("FAIL lu_instr: got %h want %h", bus0.o_instr_d, 32'h1000_0002); end
    tests++; if (bus0.o_imem_addr !== 32'd12) begin fails++; $display("FAIL lu_addr: got %h want %h", bus0.o_imem_addr, 32'd12); end
    tests++; if (bus0.o_stall_cnt !== 16'd1) begin fails++; $display("FAIL lu_stall_cnt: got %0d want 1", bus0.o_stall_cnt); end
    step();
    tests++; if (bus0.o_pc_d !== 32'd12 || bus0.o_instr_d !== 32'h1000_0003) begin fails++; $display("FAIL lu_next: got %h/%h want %h/%h", bus0.o_pc_d, bus0.o_instr_d, 32'd12, 32'h1000_0003); end
  endtask

  task automatic test_stall_hold();
    scramble = 1'b1;
    bus0.i_stall_f = 1'b1; bus0.i_stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bus0.o_pc_d !== 32'd12 || bus0.o_instr_d !== 32'h1000_0003) begin fails++; $display("FAIL hold[%0d]: got %h/%h want %h/%h", i, bus0.o_pc_d, bus0.o_instr_d, 32'd12, 32'h1000_0003); end
    end
    bus0.i_stall_f = 1'b0; bus0.i_stall_d = 1'b0; scramble = 1'b0;
    tests++; if (bus0.o_stall_cnt !== 16'd4) begin fails++; $display("FAIL hold_stall_cnt: got %0d want 4", bus0.o_stall_cnt); end
    step();
    tests++; if (bus0.o_pc_d !== 32'd16 || bus0.o_instr_d !== 32'h1000_0004) begin fails++; $display("FAIL hold_release: got %h/%h want %h/%h", bus0.o_pc_d, bus0.o_instr_d, 32'd16, 32'h1000_0004); end
    tests++; if (bus0.o_imem_addr !== 32'd20) begin fails++; $display("FAIL hold_addr: got %h want %h", bus0.o_imem_addr, 32'd20); end
  endtask

  task automatic test_branch();
    bus0.i_br_sel = 1'b1; bus0.i_flush_d = 1'b1; bus0.i_br_target = 32'h0000_0102;
    step();
    bus0.i_br_sel = 1'b0; bus0.i_flush_d = 1'b0;
    tests++; if (bus0.o_imem_addr !== 32'h100) begin fails++; $display("FAIL br_addr: got %h want %h", bus0.o_imem_addr, 32'h100); end
    tests++; if (bus0.o_valid_d !== 1'b0 || bus0.o_instr_d !== 32'h13) begin fails++; $display("FAIL br_squash: got %b/%h want 0/%h", bus0.o_valid_d, bus0.o_instr_d, 32'h13); end
    tests++; if (bus0.o_flush_cnt !== 16'd1) begin fails++; $display("FAIL br_flush_cnt: got %0d want 1", bus0.o_flush_cnt); end
    step();
    tests++; if (bus0.o_pc_d !== 32'h100 || bus0.o_valid_d !== 1'b1 || bus0.o_instr_d !== 32'h1000_0040) begin fails++; $display("FAIL br_target: got %h/%b/%h want %h/1/%h", bus0.o_pc_d, bus0.o_valid_d, bus0.o_instr_d, 32'h100, 32'h1000_0040); end
  endtask

  task automatic test_stall_flush_redirect();
    bus0.i_stall_f = 1'b1; bus0.i_stall_d = 1'b1; bus0.i_flush_d = 1'b1;
    bus0.i_br_sel = 1'b1; bus0.i_br_target = 32'h40;
    step();
    bus0.i_stall_f = 1'b0; bus0.i_stall_d = 1'b0; bus0.i_flush_d = 1'b0; bus0.i_br_sel = 1'b0;
    tests++; if (bus0.o_imem_addr !== 32'h40 || bus0.o_valid_d !== 1'b0) begin fails++; $display("FAIL sfr_squash: got %h/%b want %h/0", bus0.o_imem_addr, bus0.o_valid_d, 32'h40); end
    tests++; if (bus0.o_stall_cnt !== 16'd4 || bus0.o_flush_cnt !== 16'd2) begin fails++; $display("FAIL sfr_cnts: got %0d/%0d want 4/2", bus0.o_stall_cnt, bus0.o_flush_cnt); end
    step();
    tests++; if (bus0.o_pc_d !== 32'h40 || bus0.o_instr_d !== 32'h1000_0010 || bus0.o_valid_d !== 1'b1) begin fails++; $display("FAIL sfr_next: got %h/%h/%b want %h/%h/1", bus0.o_pc_d, bus0.o_instr_d, bus0.o_valid_d, 32'h40, 32'h1000_0010); end
  endtask

  task automatic test_saturation_reset();
    bus0.i_stall_f = 1'b1; bus0.i_stall_d = 1'b1;
    repeat (70000) step();
    tests++; if (bus0.o_stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_stall_cnt: got %h want %h", bus0.o_stall_cnt, 16'hFFFF); end
    rst_n = 1'b0;
    step();
    tests++; if (bus0.o_imem_addr !== 32'h0 || bus0.o_pc_d !== 32'h0 || bus0.o_pc4_d !== 32'h4) begin fails++; $display("FAIL midrst_pc: got %h/%h/%h want 0/0/4", bus0.o_imem_addr, bus0.o_pc_d, bus0.o_pc4_d); end
    tests++; if (bus0.o_instr_d !== 32'h13 || bus0.o_valid_d !== 1'b0) begin fails++; $display("FAIL midrst_instr: got %h/%b want %h/0", bus0.o_instr_d, bus0.o_valid_d, 32'h13); end
    tests++; if (bus0.o_stall_cnt !== 16'h0 || bus0.o_flush_cnt !== 16'h0) begin fails++; $display("FAIL midrst_cnts: got %h/%h want 0/0", bus0.o_stall_cnt, bus0.o_flush_cnt); end
    bus0.i_stall_f = 1'b0; bus0.i_stall_d = 1'b0;
  endtask

  task automatic test_wrap();
    rst1_n = 1'b1;
    step();
    tests++; if (bus1.o_pc_d !== 32'hFFFF_FFFC || bus1.o_pc4_d !== 32'h0) begin fails++; $display("FAIL wrap_first: got %h/%h want %h/0", bus1.o_pc_d, bus1.o_pc4_d, 32'hFFFF_FFFC); end
    tests++; if (bus1.o_instr_d !== 32'h4FFF_FFFF || bus1.o_valid_d !== 1'b1) begin fails++; $display("FAIL wrap_instr: got %h/%b want %h/1", bus1.o_instr_d, bus1.o_valid_d, 32'h4FFF_FFFF); end
    step();
    tests++; if (bus1.o_pc_d !== 32'h0 || bus1.o_instr_d !== 32'h1000_0000) begin fails++; $display("FAIL wrap_second: got %h/%h want 0/%h", bus1.o_pc_d, bus1.o_instr_d, 32'h1000_0000); end
  endtask

  initial begin
    bus0.i_stall_f = 1'b0; bus0.i_stall_d = 1'b0; bus0.i_flush_d = 1'b0;
    bus0.i_br_sel = 1'b0; bus0.i_br_target = '0;
    bus1.i_stall_f = 1'b0; bus1.i_stall_d = 1'b0; bus1.i_flush_d = 1'b0;
    bus1.i_br_sel = 1'b0; bus1.i_br_target = '0;
    test_reset();
    test_sequential();
    test_load_use();
    test_stall_hold();
    test_branch();
    test_stall_flush_redirect();
    test_wrap();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
